// File: rtl/mau_pkg.sv
// Shared definitions for the load/store access unit: size codes, FSM states and lane-mask helper.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, RESP, ERR} mau_state_t;

  // Lane mask spanning two bus words; low half is beat 0, the rest spills into beat 1.
  function automatic logic [15:0] byte_mask(input logic [1:0] size, input logic [2:0] off);
    logic [15:0] lanes;
    case (size)
      SZ_B:    lanes = 16'h0001;
      SZ_H:    lanes = 16'h0003;
      SZ_W:    lanes = 16'h000F;
      default: lanes = 16'h00FF;
    endcase
    return lanes << off;
  endfunction

endpackage

// File: rtl/mem_access_unit_ld_align_ext.sv
// Load result extension: keeps the low 1<<size bytes of the merged buffer and fills
// the rest with the top data bit (signed) or zero.
module ld_align_ext
  import mau_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [DW-1:0] data_i,
  input  logic [1:0]    size_i,
  input  logic          signed_i,
  output logic [DW-1:0] data_o
);

  logic top_bit;
  int   nb;

  always_comb begin
    top_bit = data_i[DW-1];
    nb      = DW / 8;
    case (size_i)
      SZ_B: begin top_bit = data_i[7];  nb = 1; end
      SZ_H: begin top_bit = data_i[15]; nb = 2; end
      SZ_W: begin top_bit = data_i[31]; nb = 4; end
      default: begin top_bit = data_i[DW-1]; nb = DW / 8; end
    endcase
  end

  generate
    for (genvar gi = 0; gi < DW / 8; gi++) begin : g_lane
      assign data_o[8*gi +: 8] = (gi < nb) ? data_i[8*gi +: 8] : {8{signed_i & top_bit}};
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Handshaked load/store data path between the CPU MEM stage and the data bus.
// Define MAU_MISALIGN_SPLIT_EN to run word-crossing accesses as two bus beats.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_signed,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            rsp_valid,
  output logic            rsp_err,
  output logic [DW-1:0]   rsp_rdata,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int OB   = DW / 8;
  localparam int OFFW = $clog2(OB);

  mau_state_t      state_q, state_d;
  logic            we_q;
  logic [1:0]      size_q;
  logic            signed_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rbuf_q, rbuf_d;

  logic            req_illegal;
  logic [OFFW-1:0] off_q;
  logic [AW-1:0]   base_addr;
  logic [DW-1:0]   ext_data;
  int              lo_shift;

  assign off_q     = addr_q[OFFW-1:0];
  assign lo_shift  = 8 * int'(off_q);
  assign base_addr = {addr_q[AW-1:OFFW], {OFFW{1'b0}}};

`ifdef MAU_MISALIGN_SPLIT_EN
  logic acc_cross;
  int   hi_shift;
  assign acc_cross   = (int'(off_q) + (1 << size_q)) > OB;
  assign hi_shift    = 8 * (OB - int'(off_q));
  assign req_illegal = (DW == 32) && (req_size == SZ_D);
`else
  logic req_cross;
  assign req_cross   = (int'(req_addr[OFFW-1:0]) + (1 << req_size)) > OB;
  assign req_illegal = ((DW == 32) && (req_size == SZ_D)) || req_cross;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      size_q   <= SZ_B;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
    end else begin
      state_q <= state_d;
      rbuf_q  <= rbuf_d;
      if (req_valid && req_ready) begin
        we_q     <= req_we;
        size_q   <= req_size;
        signed_q <= req_signed;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    rbuf_d    = rbuf_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_be    = '0;
    mem_wdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = req_illegal ? ERR : ACC0;
      end
      ACC0: begin
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr;
        mem_be    = OB'(byte_mask(size_q, 3'(off_q)));
        mem_wdata = wdata_q << lo_shift;
        if (mem_ready) begin
          rbuf_d = mem_rdata >> lo_shift;
`ifdef MAU_MISALIGN_SPLIT_EN
          state_d = acc_cross ? ACC1 : RESP;
`else
          state_d = RESP;
`endif
        end
      end
`ifdef MAU_MISALIGN_SPLIT_EN
      ACC1: begin
        // Second word wraps to address 0 at the top of the address space.
        mem_valid = 1'b1;
        mem_we    = we_q;
        mem_addr  = base_addr + AW'(OB);
        mem_be    = OB'(byte_mask(size_q, 3'(off_q)) >> OB);
        mem_wdata = wdata_q >> hi_shift;
        if (mem_ready) begin
          rbuf_d  = rbuf_q | (mem_rdata << hi_shift);
          state_d = RESP;
        end
      end
`endif
      RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = we_q ? '0 : ext_data;
        state_d   = IDLE;
      end
      ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  ld_align_ext #(.DW(DW)) u_ld_align_ext (
    .data_i   (rbuf_q),
    .size_i   (size_q),
    .signed_i (signed_q),
    .data_o   (ext_data)
  );

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (DW=32); expectations follow the build's MAU_MISALIGN_SPLIT_EN setting.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DW(32), .AW(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input string tag, input logic we, input logic [1:0] size,
                      input logic sgn, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    chk({tag, ".ready"}, req_ready, 1'b1);
    chk({tag, ".rsp_idle"}, rsp_valid, 1'b0);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    $display("req %s: we=%0b size=%0d signed=%0b addr=0x%08h wdata=0x%08h", tag, we, size, sgn, addr, wdata);
  endtask

  task automatic beat(input string tag, input logic [31:0] addr, input logic [3:0] be,
                      input logic we, input logic [31:0] wdata, input logic [31:0] rdata);
    @(negedge clk);
    chk({tag, ".mem_valid"}, mem_valid, 1'b1);
    chk({tag, ".mem_addr"}, mem_addr, addr);
    chk({tag, ".mem_be"}, mem_be, be);
    chk({tag, ".mem_we"}, mem_we, we);
    if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
    mem_ready = 1'b1; mem_rdata = rdata;
    @(posedge clk);
    #1 mem_ready = 1'b0; mem_rdata = '0;
    $display("beat %s: addr=0x%08h be=%04b wdata=0x%08h rdata=0x%08h", tag, mem_addr, be, wdata, rdata);
  endtask

  task automatic resp(input string tag, input logic err, input logic [31:0] rdata);
    @(negedge clk);
    chk({tag, ".rsp_valid"}, rsp_valid, 1'b1);
    chk({tag, ".rsp_err"}, rsp_err, err);
    chk({tag, ".rsp_rdata"}, rsp_rdata, rdata);
    chk({tag, ".mem_idle"}, mem_valid, 1'b0);
    $display("rsp %s: err=%0b rdata=0x%08h", tag, rsp_err, rsp_rdata);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = SZ_B; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; mem_ready = 1'b0; mem_rdata = '0;

    @(negedge clk);
    chk("rst.req_ready", req_ready, 1'b1);
    chk("rst.rsp_valid", rsp_valid, 1'b0);
    chk("rst.rsp_err", rsp_err, 1'b0);
    chk("rst.rsp_rdata", rsp_rdata, 32'h0);
    chk("rst.mem_valid", mem_valid, 1'b0);
    chk("rst.mem_we", mem_we, 1'b0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_be", mem_be, 4'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    $display("reset checked");
    rst = 1'b0;

    // Signed byte load from lane 3
    send("lb", 1'b0, SZ_B, 1'b1, 32'h0000_1003, 32'h0);
    beat("lb", 32'h0000_1000, 4'b1000, 1'b0, 32'h0, 32'h80FF_1234);
    resp("lb", 1'b0, 32'hFFFF_FF80);

    send("lhu", 1'b0, SZ_H, 1'b0, 32'h0000_2002, 32'h0);
    beat("lhu", 32'h0000_2000, 4'b1100, 1'b0, 32'h0, 32'hBEEF_0000);
    resp("lhu", 1'b0, 32'h0000_BEEF);

    send("lh", 1'b0, SZ_H, 1'b1, 32'h0000_2002, 32'h0);
    beat("lh", 32'h0000_2000, 4'b1100, 1'b0, 32'h0, 32'hBEEF_0000);
    resp("lh", 1'b0, 32'hFFFF_BEEF);

    // Byte store; signed flag must not affect the store result
    send("sb", 1'b1, SZ_B, 1'b1, 32'h0000_3001, 32'h0000_0077);
    beat("sb", 32'h0000_3000, 4'b0010, 1'b1, 32'h0000_7700, 32'hFFFF_FFFF);
    resp("sb", 1'b0, 32'h0);

    send("sw_x", 1'b1, SZ_W, 1'b0, 32'h0000_0005, 32'hAABB_CCDD);
`ifdef MAU_MISALIGN_SPLIT_EN
    beat("sw_x.b0", 32'h0000_0004, 4'b1110, 1'b1, 32'hBBCC_DD00, 32'h0);
    beat("sw_x.b1", 32'h0000_0008, 4'b0001, 1'b1, 32'h0000_00AA, 32'h0);
    resp("sw_x", 1'b0, 32'h0);
`else
    resp("sw_x", 1'b1, 32'h0);
`endif

    // Dword size is illegal on a 32-bit bus in both builds
    send("ld_d", 1'b0, SZ_D, 1'b0, 32'h0000_0000, 32'h0);
    resp("ld_d", 1'b1, 32'h0);

    send("lw_wrap", 1'b0, SZ_W, 1'b1, 32'hFFFF_FFFE, 32'h0);
`ifdef MAU_MISALIGN_SPLIT_EN
    beat("lw_wrap.b0", 32'hFFFF_FFFC, 4'b1100, 1'b0, 32'h0, 32'h1234_0000);
    beat("lw_wrap.b1", 32'h0000_0000, 4'b0011, 1'b0, 32'h0, 32'h0000_ABCD);
    resp("lw_wrap", 1'b0, 32'hABCD_1234);
`else
    resp("lw_wrap", 1'b1, 32'h0);
`endif

    // Bus hold under five wait states
    send("stall", 1'b1, SZ_W, 1'b0, 32'h0000_0040, 32'h1122_3344);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall.mem_valid", mem_valid, 1'b1);
      chk("stall.mem_addr", mem_addr, 32'h0000_0040);
      chk("stall.mem_be", mem_be, 4'b1111);
      chk("stall.mem_wdata", mem_wdata, 32'h1122_3344);
      chk("stall.rsp_valid", rsp_valid, 1'b0);
      $display("stall cycle %0d: addr=0x%08h be=%04b wdata=0x%08h", i, mem_addr, mem_be, mem_wdata);
    end
    beat("stall", 32'h0000_0040, 4'b1111, 1'b1, 32'h1122_3344, 32'h0);
    resp("stall", 1'b0, 32'h0);

    // Asynchronous reset in the middle of an access
`ifdef MAU_MISALIGN_SPLIT_EN
    send("rst_mid", 1'b1, SZ_W, 1'b0, 32'h0000_0005, 32'hAABB_CCDD);
    beat("rst_mid.b0", 32'h0000_0004, 4'b1110, 1'b1, 32'hBBCC_DD00, 32'h0);
    @(negedge clk);
    chk("rst_mid.acc1_valid", mem_valid, 1'b1);
    chk("rst_mid.acc1_addr", mem_addr, 32'h0000_0008);
`else
    send("rst_mid", 1'b0, SZ_W, 1'b0, 32'h0000_0080, 32'h0);
    @(negedge clk);
    chk("rst_mid.acc0_valid", mem_valid, 1'b1);
    chk("rst_mid.acc0_addr", mem_addr, 32'h0000_0080);
`endif
    #2 rst = 1'b1;
    #1;
    chk("rst_mid.mem_valid", mem_valid, 1'b0);
    chk("rst_mid.req_ready", req_ready, 1'b1);
    chk("rst_mid.rsp_valid", rsp_valid, 1'b0);
    $display("reset asserted mid-access");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid.no_rsp", rsp_valid, 1'b0);
      chk("rst_mid.no_beat", mem_valid, 1'b0);
    end

    send("lbu", 1'b0, SZ_B, 1'b0, 32'h0000_0002, 32'h0);
    beat("lbu", 32'h0000_0000, 4'b0100, 1'b0, 32'h0, 32'h00AB_0000);
    resp("lbu", 1'b0, 32'h0000_00AB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Parametrised load/store data path between the multi-cycle CPU's MEM stage and the data memory bus. It accepts one load or store request at a time and generates byte enables and shifted write data. Read data is aligned and sign- or zero-extended. With the split feature compiled in, an access that crosses a bus-word boundary becomes two bus beats. It replaces the purely combinational load-extension path with a handshaked, stateful unit that supports 32- or 64-bit buses.

## Interface
- DW, 32, data/bus width in bits; 32 or 64
- AW, 32, address width
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (legal only when DW=64)
- req_signed  in  1  sign-extend load result
- req_addr  in  AW  byte address
- req_wdata  in  DW  store data, right-justified
- rsp_valid  out  1  one-cycle completion pulse
- rsp_err  out  1  qualifies rsp_valid: illegal size, or misaligned access
- rsp_rdata  out  DW  extended load data; 0 for stores and errors
- mem_valid  out  1  bus beat request
- mem_ready  in  1  beat accepted; for loads, mem_rdata is valid in the same cycle
- mem_we  out  1  beat is a write
- mem_addr  out  AW  bus-word-aligned address (low log2(DW/8) bits = 0)
- mem_be  out  DW/8  byte enables
- mem_wdata  out  DW  lane-positioned write data
- mem_rdata  in  DW  read data

## Operation
- States: IDLE, ACC0, ACC1, RESP, ERR.
- Accept: the request is accepted when req_valid and req_ready are both high. On acceptance, the unit latches all req_* fields.
- Derived values:
  - off = addr[log2(DW/8)-1:0]
  - nb = 1<<size
  - cross = (off+nb > DW/8)
- Illegal request (size=3 with DW=32, or cross with the split feature absent):
  - IDLE→ERR; no bus activity.
  - ERR lasts one cycle: rsp_valid=1, rsp_err=1, rsp_rdata=0, then →IDLE.
- Beat 0 (ACC0):
  - mem_addr = addr with low bits cleared.
  - mem_be = ((1<<nb)-1)<<off, truncated to DW/8 bits.
  - mem_wdata = wdata<<(8*off).
  - On mem_ready: go to ACC1 if cross, else RESP.
  - For loads, the low half of the merge buffer captures mem_rdata>>(8*off).
- Beat 1 (ACC1):
  - mem_addr = beat-0 address + DW/8, modulo 2^AW (wraps to 0 at top of address space).
  - mem_be = the remaining low lanes.
  - mem_wdata = wdata>>(8*(DW/8-off)).
  - On mem_ready: go to RESP. For loads, mem_rdata lanes are merged above the beat-0 bytes.
- RESP lasts one cycle: rsp_valid=1, rsp_err=0, then →IDLE.
  - rsp_rdata = merged bytes masked to nb bytes.
  - Upper bits are filled with the top data bit when req_signed, else 0.
- Bus hold: mem_* outputs are stable while mem_valid=1 and mem_ready=0. mem_valid=1 only in ACC0/ACC1.
- Store results: rsp_rdata=0; req_signed is ignored.

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_valid=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Latency, with acceptance at cycle T and zero-wait memory:
  - aligned access: beat at T+1, rsp_valid at T+2
  - split access: beats at T+1 and T+2, rsp_valid at T+3
  - error: rsp_valid at T+1
- Wait states: each cycle with mem_ready low adds one cycle of latency.
- Back-to-back: a new request can be accepted in the cycle after rsp_valid; there is no overlap.
- Reset mid-operation (any state): mem_valid drops asynchronously, no rsp_valid is produced, and the latched request is discarded.

## Configuration
- MAU_MISALIGN_SPLIT_EN defined: boundary-crossing accesses execute as two beats with merged/split data.
- MAU_MISALIGN_SPLIT_EN undefined: crossing accesses go to ERR. ACC1 and the merge buffer upper half are not synthesised.
- In both builds, accesses that are naturally aligned or stay within one bus word behave identically.

## Structure
- Shared package mau_pkg holds:
  - size encoding constants SZ_B, SZ_H, SZ_W, SZ_D
  - state enum mau_state_t
  - the function computing the byte mask from size and offset
- Sub-module ld_align_ext is combinational and parametrised by DW. It takes the merged buffer, size, and signed flag, and produces rsp_rdata. It is the generalised successor of the old load-extension logic.

## Test plan
- DW=32, signed byte load at 0x1003, mem_rdata=0x80FF1234 → mem_be=4'b1000, rsp_rdata=0xFFFFFF80 at T+2.
- Unsigned half load at 0x2002, mem_rdata=0xBEEF0000 → mem_be=4'b1100, rsp_rdata=0x0000BEEF.
- Split on: word store 0xAABBCCDD at 0x5 → two beats, then rsp_err=0:
  - beat 0: addr 0x4, be 1110, wdata 0xBBCCDD00
  - beat 1: addr 0x8, be 0001, wdata 0x000000AA
- Split off: same store → rsp_valid=1, rsp_err=1 at T+1; mem_valid never asserted. DW=32 with size=3 → error in both builds.
- Split on: signed word load at 0xFFFFFFFE → beat-1 mem_addr=0x00000000.
  - beat 0: mem_rdata=0x12340000
  - beat 1: mem_rdata=0x0000ABCD
  - Required result: rsp_rdata=0xABCD1234.
- Stalls and reset:
  - Hold mem_ready low for 5 cycles in ACC0 → mem_* unchanged throughout.
  - Assert rst during ACC1 → mem_valid=0 immediately, no rsp_valid, req_ready=1.
